mem_rd_stream: RTL
==================

Name: mem_rd_stream

Overview:
- Read-side client of the 512x8 dual-port block RAM, which has a registered read address and one cycle of read latency.
- Given a base address and length, it issues sequential read addresses, captures the returned bytes and presents them as a valid/ready byte stream.
- It absorbs the RAM's fixed latency and downstream backpressure with a 2-entry capture buffer. No byte is dropped or duplicated.
- It is used by DMA/UART-dump style consumers of on-chip data memory.

Parameters:
- ADDR_W, 9, RAM address width (depth 2**ADDR_W = 512).
- DATA_W, 8, RAM/stream data width.
- LEN_W, 10, transfer length width (lengths 0..512).

Ports:
- i_clk  input  1  clock; sole clock domain.
- i_nrst  input  1  reset; synchronous, active-low.
- i_start  input  1  start request; sampled only in IDLE.
- i_base  input  ADDR_W  first read address; sampled with i_start.
- i_len  input  LEN_W  byte count; sampled with i_start; values >512 are clipped to 512.
- o_busy  output  1  transfer in progress.
- o_done  output  1  one-cycle pulse at transfer completion.
- o_raddr  output  ADDR_W  to RAM read address.
- i_rdata  input  DATA_W  from RAM; holds mem[addr presented in previous cycle].
- o_valid  output  1  stream byte valid.
- o_data  output  DATA_W  stream byte.
- i_ready  input  1  downstream accepts when o_valid&i_ready.

Behaviour:
- Reset (i_nrst low at a rising edge) forces state IDLE, buffer empty, counters 0, in-flight flag 0.
  - Outputs after reset: o_busy=0, o_done=0, o_valid=0, o_data=0, o_raddr=0.
  - Reset mid-transfer aborts the transfer. Data in flight is discarded and no o_done is generated.
- States:
  - IDLE: i_start=1 latches base and len. Goes to RUN; if clipped len==0, goes to DONE instead.
  - RUN: issue reads and drain. Goes to DONE in the cycle of the final handshake.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- o_busy=1 in RUN only.
- i_start outside IDLE is ignored; base and len are not re-sampled.
- Issue rule, per RUN cycle: a read issues iff issued<len AND (buf_count + inflight − pop) < 2.
  - pop = o_valid & i_ready.
  - On issue: o_raddr = current address, inflight<=1, address and issued count advance.
  - With no issue: o_raddr holds its last value and inflight<=0.
- Address arithmetic is modulo 512. 0x1FF is followed by 0x000.
- Capture: when inflight=1, i_rdata is written into the buffer at the following edge. It is valid for that cycle only and must never be missed; the issue rule guarantees a free slot.
- o_valid/o_data come from the buffer head register, never combinationally from i_rdata.
  - o_data is stable while o_valid & !i_ready.
- Simultaneous push and pop in one cycle is legal, including when the buffer is full.
- Latency: with i_start at cycle 0, the first read issues at cycle 1, i_rdata is valid at cycle 2, and o_valid is first asserted at cycle 3.
- Throughput: 1 byte/cycle sustained when i_ready=1.
- Completion: the final handshake occurs at cycle N. o_done=1 and o_busy=0 at cycle N+1. A new i_start is accepted from cycle N+2.
- Length 0: o_busy stays 0, o_done=1 at cycle 1, no read issued, o_valid never asserted.

Decomposition:
- Shared package mem_pkg holds:
  - constants MEM_ADDR_W=9, MEM_DATA_W=8, MEM_DEPTH=512;
  - the rd-stream state enum {IDLE, RUN, DONE}.
- One sub-module, fifo2_skid: 2-entry, DATA_W-wide, register-based FIFO.
  - Ports: push, data in, pop, head data out, count[1:0].
  - Same clock and synchronous active-low reset.
- Control, counters and the issue rule stay in mem_rd_stream.

Test Plan:
- Base 0x010, len 4, i_ready=1, RAM preloaded with mem[a]=a[7:0] -> o_raddr 0x010..0x013 in cycles 1..4. o_data 0x10,0x11,0x12,0x13 valid in cycles 3..6. o_done in cycle 7 only.
- Base 0x1FE, len 4 -> read addresses 0x1FE, 0x1FF, 0x000, 0x001. Stream bytes are FE, FF, 00, 01.
- Base 0x000, len 8, i_ready low for cycles 4..9 and then high:
  - the first byte is held stable throughout the stall;
  - no more than 2 reads are buffered or in flight;
  - all 8 bytes arrive in order with no duplicates;
  - o_done comes 1 cycle after the 8th handshake.
- Random i_ready at 50% over base 0x000, len 512 -> all 512 bytes in order and exactly one o_done. i_start pulses during the transfer are ignored.
- len 0 -> o_done at cycle 1, o_valid never asserted, o_busy stays 0.
- i_nrst low for 1 cycle after the 3rd byte of a len-10 transfer:
  - all outputs return to reset values, with no o_done;
  - a following start (base 0x100, len 2) streams mem[0x100], mem[0x101] correctly.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared data-memory constants and the read-stream FSM state type
package mem_pkg;
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH = 512;
  typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;
endpackage

// File: rtl/mem_rd_stream_if.sv
// mem_rd_stream_if: valid/ready byte stream carrying data read out of memory
interface mem_rd_stream_if import mem_pkg::*; #(
  parameter int DATA_W = MEM_DATA_W
);
  logic valid;
  logic [DATA_W-1:0] data;
  logic ready;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/fifo2_skid.sv
// fifo2_skid: 2-entry register FIFO; dout is the head, push and pop may coincide even when full
module fifo2_skid import mem_pkg::*; #(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic push,
  input  logic [DATA_W-1:0] din,
  input  logic pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0] count
);
  logic [DATA_W-1:0] tail;
  always_ff @(posedge i_clk)
    if (!i_nrst) begin
      dout <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      dout <= push && (count == 2'd0 || (count == 2'd1 && pop)) ? din :
              pop && count == 2'd2 ? tail : dout;
      tail <= push && ((count == 2'd1 && !pop) || count == 2'd2) ? din : tail;
    end
endmodule

// File: rtl/mem_rd_stream.sv
// mem_rd_stream: issues sequential RAM reads and streams the returned bytes over valid/ready
module mem_rd_stream import mem_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W = 10
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0] i_len,
  output logic o_busy,
  output logic o_done,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  mem_rd_stream_if.master strm
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);
  rd_state_t state;
  logic [ADDR_W-1:0] addr, raddr_q;
  logic [LEN_W-1:0] len, len_c, issued, popped;
  logic inflight, issue, pop, last;
  logic [1:0] count;
  assign len_c = i_len > MAX_LEN ? MAX_LEN : i_len;
  assign pop = strm.valid & strm.ready;
  // a read is only issued when its byte is guaranteed a buffer slot on return
  assign issue = state == RUN && issued < len &&
                 {1'b0, count} + {2'b0, inflight} < 3'd2 + {2'b0, pop};
  assign last = pop && popped == len - LEN_W'(1);
  assign o_raddr = issue ? addr : raddr_q;
  assign strm.valid = |count;
  fifo2_skid #(.DATA_W(DATA_W)) u_buf (
    .i_clk(i_clk),
    .i_nrst(i_nrst),
    .push(inflight),
    .din(i_rdata),
    .pop(pop),
    .dout(strm.data),
    .count(count)
  );
  always_ff @(posedge i_clk)
    if (!i_nrst) begin
      state <= IDLE;
      addr <= '0;
      raddr_q <= '0;
      len <= '0;
      issued <= '0;
      popped <= '0;
      inflight <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      raddr_q <= o_raddr;
      inflight <= issue;
      if (issue) begin
        addr <= addr + 1'b1;
        issued <= issued + 1'b1;
      end
      if (pop) popped <= popped + 1'b1;
      case (state)
        IDLE: if (i_start) begin
          addr <= i_base;
          len <= len_c;
          issued <= '0;
          popped <= '0;
          state <= len_c == '0 ? DONE : RUN;
          o_busy <= len_c != '0;
          o_done <= len_c == '0;
        end
        RUN: if (last) begin
          state <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          o_done <= 1'b0;
        end
      endcase
    end
endmodule
